alu_operand_skid: RTL and testbench

Two-entry registered skid buffer between the decode stage and the ALU (logical, arithmetic and shift units) in the Mini RISC datapath. It holds decoded operations (operands, ALU opcode, destination register) under a valid/ready handshake. While an operation waits, it refreshes any stale operand from the writeback port. Each ALU-bound operation is registered exactly once, so the ALU sees stable `src1`/`src2`/`aluOp` for the whole cycle.

---
 rtl/alu_operand_skid.sv | 113 +++++++++++
 tb/tb_alu_operand_skid.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_skid.sv
// Two-entry registered skid buffer between decode and the ALU.
// Held operands are refreshed from the writeback port while they wait.
module alu_operand_skid #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_src1,
    input  logic [DATA_W-1:0] in_src2,
    input  logic [REG_W-1:0]  in_rs1,
    input  logic [REG_W-1:0]  in_rs2,
    input  logic [OP_W-1:0]   in_aluOp,
    input  logic [REG_W-1:0]  in_rd,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_src1,
    output logic [DATA_W-1:0] out_src2,
    output logic [OP_W-1:0]   out_aluOp,
    output logic [REG_W-1:0]  out_rd
);

    typedef struct packed {
        logic [DATA_W-1:0] src1;
        logic [DATA_W-1:0] src2;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [OP_W-1:0]   op;
        logic [REG_W-1:0]  rd;
    } entry_t;

    entry_t main_q;
    entry_t skid_q;
    entry_t in_e;
    logic   main_valid;
    logic   skid_valid;
    logic   in_fire;
    logic   out_fire;
    logic   wb_hit;

    function automatic entry_t fwd(
        input entry_t            e,
        input logic              hit,
        input logic [REG_W-1:0]  rd,
        input logic [DATA_W-1:0] d
    );
        entry_t r;
        r = e;
        if (hit && e.rs1 == rd) r.src1 = d;
        if (hit && e.rs2 == rd) r.src2 = d;
        return r;
    endfunction

    assign in_e = '{
        src1: in_src1,
        src2: in_src2,
        rs1:  in_rs1,
        rs2:  in_rs2,
        op:   in_aluOp,
        rd:   in_rd
    };

    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = main_valid && out_ready;
    // x0 is hardwired to zero, so a write to it never reaches an operand.
    assign wb_hit    = wb_en && (wb_rd != '0);

    assign out_src1  = main_q.src1;
    assign out_src2  = main_q.src2;
    assign out_aluOp = main_q.op;
    assign out_rd    = main_q.rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            main_q <= fwd(main_q, wb_hit, wb_rd, wb_data);
            skid_q <= fwd(skid_q, wb_hit, wb_rd, wb_data);
            // Head slot frees up: refill from skid first to keep FIFO order.
            if (!main_valid || out_fire) begin
                if (skid_valid) begin
                    main_q     <= fwd(skid_q, wb_hit, wb_rd, wb_data);
                    main_valid <= 1'b1;
                    skid_valid <= 1'b0;
                end else if (in_fire) begin
                    main_q     <= fwd(in_e, wb_hit, wb_rd, wb_data);
                    main_valid <= 1'b1;
                end else begin
                    main_valid <= 1'b0;
                end
            end else if (in_fire) begin
                skid_q     <= fwd(in_e, wb_hit, wb_rd, wb_data);
                skid_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_skid.sv
// Bench for alu_operand_skid: vector table, directed corner
// sequences and a queue scoreboard that follows every handshake.
module tb_alu_operand_skid;

    localparam int DW = 32;
    localparam int OW = 4;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_src1;
    logic [DW-1:0] in_src2;
    logic [RW-1:0] in_rs1;
    logic [RW-1:0] in_rs2;
    logic [OW-1:0] in_aluOp;
    logic [RW-1:0] in_rd;
    logic          flush;
    logic          wb_en;
    logic [RW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_src1;
    logic [DW-1:0] out_src2;
    logic [OW-1:0] out_aluOp;
    logic [RW-1:0] out_rd;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_operand_skid #(.DATA_W(DW), .OP_W(OW), .REG_W(RW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_src1(in_src1), .in_src2(in_src2),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_aluOp(in_aluOp), .in_rd(in_rd),
        .flush(flush),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_src1(out_src1), .out_src2(out_src2),
        .out_aluOp(out_aluOp), .out_rd(out_rd)
    );

    typedef struct {
        logic [DW-1:0] src1;
        logic [DW-1:0] src2;
        logic [RW-1:0] rs1;
        logic [RW-1:0] rs2;
        logic [OW-1:0] op;
        logic [RW-1:0] rd;
    } op_t;

    op_t sbq[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: an ordered list of held ops, with writeback applied.
    always @(negedge rst_n) sbq.delete();

    always @(negedge clk) begin
        op_t e;
        if (rst_n !== 1'b1) begin
            sbq.delete();
        end else begin
            check("sb_out_valid", 32'(out_valid), 32'(sbq.size() != 0));
            check("sb_in_ready", 32'(in_ready), 32'(sbq.size() < 2));
            if (out_valid && out_ready && sbq.size() > 0) begin
                e = sbq.pop_front();
                check("sb_src1", out_src1, e.src1);
                check("sb_src2", out_src2, e.src2);
                check("sb_op", 32'(out_aluOp), 32'(e.op));
                check("sb_rd", 32'(out_rd), 32'(e.rd));
            end
            if (flush) begin
                sbq.delete();
            end else begin
                if (wb_en && wb_rd != 0) begin
                    foreach (sbq[i]) begin
                        if (sbq[i].rs1 == wb_rd) sbq[i].src1 = wb_data;
                        if (sbq[i].rs2 == wb_rd) sbq[i].src2 = wb_data;
                    end
                end
                if (in_valid && in_ready && sbq.size() < 2) begin
                    e.src1 = in_src1;
                    e.src2 = in_src2;
                    e.rs1  = in_rs1;
                    e.rs2  = in_rs2;
                    e.op   = in_aluOp;
                    e.rd   = in_rd;
                    if (wb_en && wb_rd != 0 && in_rs1 == wb_rd)
                        e.src1 = wb_data;
                    if (wb_en && wb_rd != 0 && in_rs2 == wb_rd)
                        e.src2 = wb_data;
                    sbq.push_back(e);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [DW-1:0] s1, input logic [DW-1:0] s2,
                         input logic [RW-1:0] r1, input logic [RW-1:0] r2,
                         input logic [OW-1:0] op, input logic [RW-1:0] rd);
        in_valid = 1'b1;
        in_src1  = s1;
        in_src2  = s2;
        in_rs1   = r1;
        in_rs2   = r2;
        in_aluOp = op;
        in_rd    = rd;
    endtask

    typedef struct {
        logic [RW-1:0] rs1;
        logic [RW-1:0] rs2;
        logic [DW-1:0] s1;
        logic [DW-1:0] s2;
        logic [OW-1:0] op;
        logic [RW-1:0] rd;
        logic          we;
        logic [RW-1:0] wrd;
        logic [DW-1:0] wd;
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
    } vec_t;

    vec_t vt[6];

    initial begin
        vt[0] = '{5'd1, 5'd7, 32'h1, 32'h2, 4'h1, 5'd10,
                  1'b1, 5'd7, 32'h55, 32'h1, 32'h55};
        vt[1] = '{5'd9, 5'd9, 32'h3, 32'h4, 4'h2, 5'd11,
                  1'b1, 5'd9, 32'hCAFE, 32'hCAFE, 32'hCAFE};
        vt[2] = '{5'd0, 5'd0, 32'h5, 32'h6, 4'h3, 5'd12,
                  1'b1, 5'd0, 32'h77, 32'h5, 32'h6};
        vt[3] = '{5'd4, 5'd8, 32'h7, 32'h8, 4'h4, 5'd13,
                  1'b0, 5'd4, 32'h99, 32'h7, 32'h8};
        vt[4] = '{5'd31, 5'd2, 32'h9, 32'hA, 4'hF, 5'd31,
                  1'b1, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hA};
        vt[5] = '{5'd3, 5'd3, 32'hB, 32'hC, 4'h0, 5'd1,
                  1'b1, 5'd2, 32'h1, 32'hB, 32'hC};

        rst_n = 1'b0;
        in_valid = 0; in_src1 = 0; in_src2 = 0; in_rs1 = 0; in_rs2 = 0;
        in_aluOp = 0; in_rd = 0; flush = 0;
        wb_en = 0; wb_rd = 0; wb_data = 0; out_ready = 0;
        cyc();
        cyc();
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_src1", out_src1, 0);
        check("rst_src2", out_src2, 0);
        check("rst_op", 32'(out_aluOp), 0);
        check("rst_rd", 32'(out_rd), 0);
        rst_n = 1'b1;
        cyc();

        // Single operation
        out_ready = 1'b1;
        drive(32'hF0F0_0000, 32'h0F0F_FFFF, 5'd1, 5'd2, 4'b1000, 5'd3);
        cyc();
        in_valid = 1'b0;
        check("single_valid", 32'(out_valid), 1);
        check("single_src1", out_src1, 32'hF0F0_0000);
        check("single_src2", out_src2, 32'h0F0F_FFFF);
        check("single_op", 32'(out_aluOp), 32'h8);
        check("single_rd", 32'(out_rd), 3);
        cyc();
        check("single_empty", 32'(out_valid), 0);

        // Backpressure: A, B held, C refused until the head drains
        out_ready = 1'b0;
        drive(32'hA, 32'hA0, 5'd1, 5'd2, 4'h1, 5'd4);
        cyc();
        drive(32'hB, 32'hB0, 5'd1, 5'd2, 4'h2, 5'd5);
        cyc();
        check("bp_in_ready_lo", 32'(in_ready), 0);
        drive(32'hC, 32'hC0, 5'd1, 5'd2, 4'h3, 5'd6);
        cyc();
        check("bp_c_refused", 32'(in_ready), 0);
        check("bp_head_a", out_src1, 32'hA);
        out_ready = 1'b1;
        cyc();
        check("bp_head_b", out_src1, 32'hB);
        check("bp_in_ready_hi", 32'(in_ready), 1);
        cyc();
        in_valid = 1'b0;
        check("bp_head_c", out_src1, 32'hC);
        check("bp_rd_c", 32'(out_rd), 6);
        cyc();
        check("bp_drained", 32'(out_valid), 0);

        // Forwarding into held main and skid entries
        out_ready = 1'b0;
        drive(32'h1111, 32'h2222, 5'd5, 5'd6, 4'h5, 5'd7);
        cyc();
        drive(32'hAAAA, 32'hBBBB, 5'd0, 5'd5, 4'h6, 5'd8);
        cyc();
        in_valid = 1'b0;
        wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
        cyc();
        wb_en = 1'b0;
        check("fwd_src1", out_src1, 32'hDEAD_BEEF);
        check("fwd_src2_keep", out_src2, 32'h2222);
        wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234_5678;
        cyc();
        wb_en = 1'b0;
        check("fwd_x0_src1", out_src1, 32'hDEAD_BEEF);
        check("fwd_x0_src2", out_src2, 32'h2222);
        out_ready = 1'b1;
        cyc();
        check("fwd_skid_src1", out_src1, 32'hAAAA);
        check("fwd_skid_src2", out_src2, 32'hDEAD_BEEF);
        cyc();
        check("fwd_drained", 32'(out_valid), 0);

        // Capture-edge forwarding vectors
        for (int i = 0; i < 6; i++) begin
            drive(vt[i].s1, vt[i].s2, vt[i].rs1, vt[i].rs2,
                  vt[i].op, vt[i].rd);
            wb_en = vt[i].we; wb_rd = vt[i].wrd; wb_data = vt[i].wd;
            cyc();
            in_valid = 1'b0;
            wb_en = 1'b0;
            check("vec_valid", 32'(out_valid), 1);
            check("vec_src1", out_src1, vt[i].e1);
            check("vec_src2", out_src2, vt[i].e2);
            check("vec_op", 32'(out_aluOp), 32'(vt[i].op));
            check("vec_rd", 32'(out_rd), 32'(vt[i].rd));
            cyc();
        end

        // Flush with both entries full and a concurrent input
        out_ready = 1'b0;
        drive(32'h50, 32'h51, 5'd1, 5'd2, 4'h1, 5'd1);
        cyc();
        drive(32'h60, 32'h61, 5'd1, 5'd2, 4'h1, 5'd2);
        cyc();
        drive(32'h70, 32'h71, 5'd1, 5'd2, 4'h1, 5'd3);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_full_valid", 32'(out_valid), 0);
        check("flush_full_ready", 32'(in_ready), 1);
        out_ready = 1'b1;
        cyc();
        check("flush_full_gone", 32'(out_valid), 0);
        // Flush with only main held, input would otherwise be accepted
        out_ready = 1'b0;
        drive(32'h80, 32'h81, 5'd1, 5'd2, 4'h1, 5'd4);
        cyc();
        drive(32'h90, 32'h91, 5'd1, 5'd2, 4'h1, 5'd5);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_main_valid", 32'(out_valid), 0);
        cyc();
        check("flush_main_gone", 32'(out_valid), 0);

        // Asynchronous reset between edges with two entries held
        drive(32'hA1, 32'hA2, 5'd1, 5'd2, 4'h1, 5'd6);
        cyc();
        drive(32'hB1, 32'hB2, 5'd1, 5'd2, 4'h1, 5'd7);
        cyc();
        in_valid = 1'b0;
        check("arst_pre_valid", 32'(out_valid), 1);
        check("arst_pre_ready", 32'(in_ready), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 0);
        check("arst_ready", 32'(in_ready), 1);
        check("arst_src1", out_src1, 0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Random traffic against the scoreboard
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_src1   = $urandom;
            in_src2   = $urandom;
            in_rs1    = 5'($urandom_range(0, 3));
            in_rs2    = 5'($urandom_range(0, 3));
            in_aluOp  = 4'($urandom);
            in_rd     = 5'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            wb_en     = 1'($urandom_range(0, 1));
            wb_rd     = 5'($urandom_range(0, 3));
            wb_data   = $urandom;
            flush     = ($urandom_range(0, 30) == 0);
            cyc();
        end
        in_valid = 1'b0; wb_en = 1'b0; flush = 1'b0; out_ready = 1'b1;
        cyc();
        cyc();
        cyc();
        check("final_empty", 32'(out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
